// File: rtl/c17_bist_pkg.sv
`default_nettype none
// ============================================================================
// Module      : c17_bist_pkg
// Description : Shared types and constants for the C17 BIST controller.
// Revision    : 1.0 - initial release
// ============================================================================
package c17_bist_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_ZERO = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // Feedback taps of x^5+x^3+1 in a shift-left register: bits 4 and 2
    localparam logic [4:0] LFSR_TAP_MASK  = 5'b10100;
    localparam logic [7:0] MISR_POLY      = 8'h1D;
    localparam int         PATTERNS       = 32;
    localparam logic [4:0] LAST_RUN_COUNT = 5'(PATTERNS - 2);

    function automatic logic [4:0] lfsr_next(input logic [4:0] s);
        return {s[3:0], ^(s & LFSR_TAP_MASK)};
    endfunction

endpackage
`default_nettype wire

// File: rtl/c17_bist_if.sv
`default_nettype none
// ============================================================================
// Module      : c17_bist_if
// Description : Control/status and CUT-facing signals of the C17 BIST.
// Revision    : 1.0 - initial release
// ============================================================================
interface c17_bist_if;
    logic       start;
    logic       abort;
    logic [4:0] pat_o;
    logic [1:0] resp_i;
    logic       busy;
    logic       done;
    logic       pass;
    logic [7:0] sig_o;

    modport master (
        output start, abort, resp_i,
        input  pat_o, busy, done, pass, sig_o
    );

    modport slave (
        input  start, abort, resp_i,
        output pat_o, busy, done, pass, sig_o
    );
endinterface
`default_nettype wire

// File: rtl/c17_misr.sv
`default_nettype none
// ============================================================================
// Module      : c17_misr
// Description : 8-bit multiple-input signature register, x^8+x^4+x^3+x^2+1.
// Revision    : 1.0 - initial release
// ============================================================================
module c17_misr
    import c17_bist_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clear,
    input  logic       en,
    input  logic [1:0] d,
    output logic [7:0] sig
);

    logic [7:0] r_sig;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sig <= 8'h00;
        end else if (clear) begin
            r_sig <= 8'h00;
        end else if (en) begin
            r_sig <= {r_sig[6:0], 1'b0} ^ ({8{r_sig[7]}} & MISR_POLY) ^ {6'b0, d};
        end
    end

    assign sig = r_sig;

endmodule
`default_nettype wire

// File: rtl/c17_bist.sv
`default_nettype none
// ============================================================================
// Module      : c17_bist
// Description : LFSR pattern generator, run control and MISR for a C17 CUT.
// Revision    : 1.0 - initial release
// ============================================================================
module c17_bist
    import c17_bist_pkg::*;
#(
    parameter logic [4:0] SEED   = 5'b00001,
    parameter logic [7:0] GOLDEN = 8'h00
) (
    input  logic       clk,
    input  logic       rst_n,
    c17_bist_if.slave  bus
);

    state_t     r_state;
    state_t     w_state_nxt;
    logic [4:0] r_pat;
    logic [4:0] r_count;
    logic       r_done;
    logic [7:0] w_sig;
    logic       w_load;
    logic       w_absorb;
    logic       w_set_done;
    logic       w_clear_done;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_load       = 1'b0;
        w_absorb     = 1'b0;
        w_set_done   = 1'b0;
        w_clear_done = 1'b0;
        if (bus.abort) begin
            w_state_nxt  = ST_IDLE;
            w_clear_done = 1'b1;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (bus.start) begin
                        w_load       = 1'b1;
                        w_clear_done = 1'b1;
                        w_state_nxt  = ST_RUN;
                    end
                end
                ST_RUN: begin
                    w_absorb = 1'b1;
                    if (r_count == LAST_RUN_COUNT) begin
                        w_state_nxt = ST_ZERO;
                    end
                end
                ST_ZERO: begin
                    w_absorb    = 1'b1;
                    w_set_done  = 1'b1;
                    w_state_nxt = ST_DONE;
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    // The all-zero pattern follows the last LFSR state and is held through DONE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pat   <= 5'b00000;
            r_count <= 5'd0;
            r_done  <= 1'b0;
        end else begin
            if (bus.abort) begin
                r_pat <= 5'b00000;
            end else if (w_load) begin
                r_pat <= SEED;
            end else if (w_absorb) begin
                r_pat <= (w_state_nxt == ST_RUN) ? lfsr_next(r_pat) : 5'b00000;
            end

            if (w_load) begin
                r_count <= 5'd0;
            end else if (w_absorb) begin
                r_count <= r_count + 5'd1;
            end

            if (w_clear_done) begin
                r_done <= 1'b0;
            end else if (w_set_done) begin
                r_done <= 1'b1;
            end
        end
    end

    c17_misr u_misr (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (w_load),
        .en    (w_absorb),
        .d     (bus.resp_i),
        .sig   (w_sig)
    );

    assign bus.pat_o = r_pat;
    assign bus.sig_o = w_sig;
    assign bus.busy  = (r_state == ST_RUN) || (r_state == ST_ZERO);
    assign bus.done  = r_done;
    assign bus.pass  = r_done && (w_sig == GOLDEN);

endmodule
`default_nettype wire
